// File: rtl/mod_sample_pacer.sv
// mod_sample_pacer
// Frame-paced bridge between the synthesizer and the audio DAC serializer.
// A codec LRCK rising edge (after synchronisation) pops one sample from a
// small FIFO onto o_sample. A producer FSM keeps the FIFO topped up. It issues
// one request at a time to the synth and converts each answer to a saturated
// signed OUT_WIDTH sample.
//
// Ports:
//   i_clk, i_rst    clock; asynchronous active-high reset
//   i_lrck          codec DACLRCK (asynchronous to i_clk)
//   o_trigger       one-cycle sample request to the synth
//   i_sample        signed synth sample, valid while i_sample_valid is high
//   i_sample_valid  synth answer strobe
//   i_clear         clears the sticky flags (a same-cycle set wins)
//   o_sample        signed sample to the DAC, held between frames
//   o_frame         one-cycle pulse in the cycle o_sample changes
//   o_fill          FIFO occupancy 0..DEPTH
//   o_underrun      sticky: LRCK frame arrived with an empty FIFO
//   o_clip          sticky: a pushed sample was saturated
//   o_timeout       sticky: synth did not answer within TIMEOUT cycles
module mod_sample_pacer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_lrck,
  output logic                   o_trigger,
  input  logic [IN_WIDTH-1:0]    i_sample,
  input  logic                   i_sample_valid,
  input  logic                   i_clear,
  output logic [OUT_WIDTH-1:0]   o_sample,
  output logic                   o_frame,
  output logic [$clog2(DEPTH):0] o_fill,
  output logic                   o_underrun,
  output logic                   o_clip,
  output logic                   o_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [PW:0]   FILL_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   FILL_ZERO = {(PW + 1){1'b0}};
  localparam logic [PW:0]   FILL_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE   = {{(PW - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW - 1){1'b0}}, 1'b1};
  // The counter starts at 0 in the trigger cycle, so hitting TIMEOUT-1 means
  // the timeout registers exactly TIMEOUT cycles after o_trigger rose.
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

  // Saturation limits expressed at the input width so the compare is signed.
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
    {{(IN_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
    {{(IN_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Returns {clipped, sample}: arithmetic shift then clamp to OUT_WIDTH.
  function automatic logic [OUT_WIDTH:0] sat_convert(input logic [IN_WIDTH-1:0] raw);
    logic signed [IN_WIDTH-1:0] v;
    v = $signed(raw) >>> SHIFT;
    if (v > SAT_MAX) begin
      sat_convert = {1'b1, 1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end else if (v < SAT_MIN) begin
      sat_convert = {1'b1, 1'b1, {(OUT_WIDTH - 1){1'b0}}};
    end else begin
      sat_convert = {1'b0, v[OUT_WIDTH-1:0]};
    end
  endfunction

  logic                 lrck_s1_r, lrck_s2_r, lrck_s3_r;
  logic                 tick_s, pop_s, push_s, trig_s, tmo_s;
  logic                 underrun_set_s, clip_set_s;
  logic [OUT_WIDTH:0]   conv_s;
  state_t               state_r, state_s;
  logic [CW-1:0]        wait_cnt_r;
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [OUT_WIDTH-1:0] mem_r [DEPTH];

  // LRCK synchroniser; s3 only serves the rising-edge detect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lrck_s1_r <= 1'b0;
      lrck_s2_r <= 1'b0;
      lrck_s3_r <= 1'b0;
    end else begin
      lrck_s1_r <= i_lrck;
      lrck_s2_r <= lrck_s1_r;
      lrck_s3_r <= lrck_s2_r;
    end
  end

  assign tick_s         = lrck_s2_r & ~lrck_s3_r;
  assign pop_s          = tick_s & (o_fill != FILL_ZERO);
  assign underrun_set_s = tick_s & (o_fill == FILL_ZERO);
  assign conv_s         = sat_convert(i_sample);
  assign clip_set_s     = push_s & conv_s[OUT_WIDTH];

  // Producer FSM next state: one outstanding request, push or give up.
  always_comb begin
    state_s = state_r;
    trig_s  = 1'b0;
    push_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (o_fill < FILL_FULL) begin
          trig_s  = 1'b1;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_sample_valid) begin
          push_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (wait_cnt_r == CNT_LAST) begin
          tmo_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Producer FSM state, registered trigger and response wait counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      o_trigger  <= 1'b0;
      wait_cnt_r <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      o_trigger <= trig_s;
      if (trig_s) begin
        wait_cnt_r <= CNT_ZERO;
      end else if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= conv_s[OUT_WIDTH-1:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2^PW.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      o_fill   <= FILL_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   o_fill <= o_fill + FILL_ONE;
        2'b01:   o_fill <= o_fill - FILL_ONE;
        default: o_fill <= o_fill;
      endcase
    end
  end

  // Consumer: present the FIFO head on each LRCK frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sample <= {OUT_WIDTH{1'b0}};
      o_frame  <= 1'b0;
    end else begin
      o_frame <= pop_s;
      if (pop_s) begin
        o_sample <= mem_r[rd_ptr_r];
      end
    end
  end

  // Sticky status flags; a set in the same cycle as i_clear takes priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_underrun <= 1'b0;
      o_clip     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      if (underrun_set_s)  o_underrun <= 1'b1;
      else if (i_clear)    o_underrun <= 1'b0;
      if (clip_set_s)      o_clip <= 1'b1;
      else if (i_clear)    o_clip <= 1'b0;
      if (tmo_s)           o_timeout <= 1'b1;
      else if (i_clear)    o_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_sample_pacer.sv
// Directed bench for mod_sample_pacer (DEPTH=4, SHIFT=0, TIMEOUT=16).
// A negedge-driven synth model answers each trigger two cycles later with the
// next queued value; when the queue is empty it stays silent.
module tb_mod_sample_pacer;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, lrck;
  logic        o_trigger, o_frame, o_underrun, o_clip, o_timeout;
  logic [31:0] i_sample;
  logic        i_sample_valid, i_clear;
  logic [15:0] o_sample;
  logic [2:0]  o_fill;

  // synth model drive and main-process drive, merged
  logic        resp_valid, resp_clear, man_valid, clr_main;
  logic [31:0] resp_sample, man_sample;
  assign i_sample_valid = resp_valid | man_valid;
  assign i_sample       = man_valid ? man_sample : resp_sample;
  assign i_clear        = resp_clear | clr_main;

  logic [31:0] src_mem [64];
  logic        src_clr [64];
  int          src_wr = 0;
  int          src_rd = 0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_trig   = 0;
  int max_fill = 0;

  always #5 clk = ~clk;

  mod_sample_pacer #(.IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(0), .DEPTH(4), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_lrck(lrck), .o_trigger(o_trigger),
    .i_sample(i_sample), .i_sample_valid(i_sample_valid), .i_clear(i_clear),
    .o_sample(o_sample), .o_frame(o_frame), .o_fill(o_fill),
    .o_underrun(o_underrun), .o_clip(o_clip), .o_timeout(o_timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic enq(input logic [31:0] v, input logic clr);
    src_mem[src_wr] = v;
    src_clr[src_wr] = clr;
    src_wr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clr_main = 1'b1;
    cycles(1);
    clr_main = 1'b0;
  endtask

  // Bounded wait for the next trigger; returns at #1 inside the trigger cycle.
  task automatic wait_trigger(output logic ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int k = 1; k <= 3 * TMO && !ok; k++) begin
      cycles(1);
      if (o_trigger) begin ok = 1'b1; lat = k; end
    end
  endtask

  // Low LRCK for 4 cycles, then rise; returns in the o_frame cycle if seen.
  task automatic do_frame(output logic seen, output logic [15:0] val, output int lat);
    lrck = 1'b0;
    cycles(4);
    lrck = 1'b1;
    seen = 1'b0;
    lat = 0;
    val = o_sample;
    for (int k = 1; k <= 8 && !seen; k++) begin
      cycles(1);
      if (o_frame) begin seen = 1'b1; lat = k; end
      val = o_sample;
    end
  endtask

  // synth model
  initial begin
    resp_valid = 1'b0; resp_clear = 1'b0; resp_sample = 32'h0;
    forever begin
      @(negedge clk);
      if (o_trigger && src_rd < src_wr) begin
        @(negedge clk);
        @(negedge clk);
        resp_sample = src_mem[src_rd];
        resp_clear  = src_clr[src_rd];
        resp_valid  = 1'b1;
        src_rd++;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_clear = 1'b0;
      end
    end
  end

  // trigger counter and occupancy high-water mark
  always @(negedge clk) begin
    if (o_trigger) n_trig++;
    if (int'(o_fill) > max_fill) max_fill = int'(o_fill);
  end

  initial begin
    logic        seen, ok;
    logic [15:0] val;
    int          lat, base, n;
    logic [15:0] exp_seq [6];

    rst = 1'b1; lrck = 1'b0; man_valid = 1'b0; man_sample = 32'h0; clr_main = 1'b0;
    cycles(3);
    // 1: reset state, then fill to DEPTH with back-to-back requests
    check_val("rst_fill", {29'h0, o_fill}, 32'h0);
    check_val("rst_sample", {16'h0, o_sample}, 32'h0);
    check_val("rst_outs", {27'h0, o_trigger, o_frame, o_underrun, o_clip, o_timeout}, 32'h0);
    enq(32'h0000_1234, 1'b0); enq(32'h2, 1'b0); enq(32'h3, 1'b0); enq(32'h4, 1'b0);
    base = n_trig;
    rst = 1'b0;
    cycles(30);
    check_val("fill_full", {29'h0, o_fill}, 32'd4);
    check_val("trig_count", n_trig - base, 32'd4);
    check_val("idle_full_flags", {29'h0, o_trigger, o_underrun, o_timeout}, 32'h0);
    check_val("no_clip_1", {31'h0, o_clip}, 32'h0);

    // 2: frame latency and head value, refill with a clipped sample
    enq(32'h0001_0000, 1'b0);
    do_frame(seen, val, lat);
    check_val("f1_seen", {31'h0, seen}, 32'h1);
    check_val("f1_latency", lat, 32'd3);
    check_val("f1_val", {16'h0, val}, 32'h1234);
    check_val("f1_fill", {29'h0, o_fill}, 32'd3);
    cycles(1);
    check_val("frame_one_cycle", {31'h0, o_frame}, 32'h0);
    cycles(10);
    check_val("refill", {29'h0, o_fill}, 32'd4);
    check_val("clip_pos", {31'h0, o_clip}, 32'h1);
    pulse_clear();
    check_val("clip_cleared", {31'h0, o_clip}, 32'h0);

    // 3: negative saturation, boundaries that must not clip, set-wins-clear
    enq(32'hFFFE_0000, 1'b0);
    do_frame(seen, val, lat);
    check_val("f2_val", {16'h0, val}, 32'h2);
    cycles(10);
    check_val("clip_neg", {31'h0, o_clip}, 32'h1);
    pulse_clear();
    check_val("clip_cleared2", {31'h0, o_clip}, 32'h0);
    enq(32'h0000_7FFF, 1'b0);
    do_frame(seen, val, lat);
    check_val("f3_val", {16'h0, val}, 32'h3);
    cycles(10);
    check_val("max_no_clip", {31'h0, o_clip}, 32'h0);
    enq(32'hFFFF_8000, 1'b0);
    do_frame(seen, val, lat);
    check_val("f4_val", {16'h0, val}, 32'h4);
    cycles(10);
    check_val("min_no_clip", {31'h0, o_clip}, 32'h0);
    enq(32'h0002_0000, 1'b1);
    do_frame(seen, val, lat);
    check_val("f5_sat_pos", {16'h0, val}, 32'h7FFF);
    cycles(10);
    check_val("clip_set_wins", {31'h0, o_clip}, 32'h1);

    // 4: drain with a silent synth, measure timeout, then underrun
    do_frame(seen, val, lat);
    check_val("f6_sat_neg", {16'h0, val}, 32'h8000);
    do_frame(seen, val, lat);
    check_val("f7_max", {16'h0, val}, 32'h7FFF);
    do_frame(seen, val, lat);
    check_val("f8_min", {16'h0, val}, 32'h8000);
    do_frame(seen, val, lat);
    check_val("f9_clipped", {16'h0, val}, 32'h7FFF);
    check_val("drained", {29'h0, o_fill}, 32'h0);
    wait_trigger(ok, lat);
    check_val("tmo_trig_wait", {31'h0, ok}, 32'h1);
    clr_main = 1'b1;
    n = 0;
    for (int k = 1; k <= 3 * TMO && n == 0; k++) begin
      cycles(1);
      clr_main = 1'b0;
      if (o_timeout) n = k;
    end
    check_val("tmo_cycles", n, TMO);
    wait_trigger(ok, lat);
    check_val("retry_trig", {31'h0, ok}, 32'h1);
    check_val("retry_lat", lat, 32'd1);
    check_val("tmo_no_push", {29'h0, o_fill}, 32'h0);
    do_frame(seen, val, lat);
    check_val("underrun_no_frame", {31'h0, seen}, 32'h0);
    check_val("underrun_hold", {16'h0, o_sample}, 32'h7FFF);
    check_val("underrun_flag", {31'h0, o_underrun}, 32'h1);

    // 5: simultaneous push/pop at fill 3, order across pointer wrap
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) enq(32'hA0 + i, 1'b0);
    cycles(30);
    check_val("wrap_fill", {29'h0, o_fill}, 32'd4);
    do_frame(seen, val, lat);
    check_val("wrap_1", {16'h0, val}, 32'hA1);
    lrck = 1'b0;
    wait_trigger(ok, lat);
    check_val("wrap_trig", {31'h0, ok}, 32'h1);
    cycles(3);
    lrck = 1'b1;
    cycles(2);
    man_sample = 32'hA5;
    man_valid = 1'b1;
    cycles(1);
    man_valid = 1'b0;
    check_val("sim_frame", {31'h0, o_frame}, 32'h1);
    check_val("sim_val", {16'h0, o_sample}, 32'hA2);
    check_val("sim_fill", {29'h0, o_fill}, 32'd3);
    enq(32'hA6, 1'b0); enq(32'hA7, 1'b0); enq(32'hA8, 1'b0);
    for (int i = 0; i < 6; i++) exp_seq[i] = 16'hA3 + 16'(i);
    for (int i = 0; i < 6; i++) begin
      do_frame(seen, val, lat);
      check_val($sformatf("wrap_seq%0d", i), {16'h0, val}, {16'h0, exp_seq[i]});
    end

    // 6: reset while waiting with fill 2; late response ignored
    do_frame(seen, val, lat);
    check_val("pre_rst_underrun", {31'h0, o_underrun}, 32'h1);
    enq(32'hB1, 1'b0); enq(32'hB2, 1'b0);
    cycles(60);
    check_val("pre_rst_fill", {29'h0, o_fill}, 32'd2);
    wait_trigger(ok, lat);
    cycles(1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_fill", {29'h0, o_fill}, 32'h0);
    check_val("mid_rst_sample", {16'h0, o_sample}, 32'h0);
    check_val("mid_rst_flags", {27'h0, o_trigger, o_frame, o_underrun, o_clip, o_timeout}, 32'h0);
    cycles(2);
    rst = 1'b0;
    man_sample = 32'h1111;
    man_valid = 1'b1;
    cycles(1);
    man_valid = 1'b0;
    cycles(4);
    check_val("late_resp_ignored", {29'h0, o_fill}, 32'h0);
    check_val("fill_bound", max_fill, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
